dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-port 16-bit data memory of the RISC core. It shares the memory's LOAD/STORE interface between port 0 (core load/store unit) and port 1 (debug/loader).
- Each port uses a req/gnt/ack handshake.
- Simultaneous requests are resolved round-robin.
- Every access is sequenced through a fixed three-state cycle.
- Read data is returned in a per-port holding register.

## Interface
- DATA_W, 16, data word width (matches memory column width)
- ADDR_W, 3, word address width (8-row data memory)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held high until gnt of that port
- we0 / we1  in  1  1 = store, 0 = load; sampled with req
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  store data
- gnt0 / gnt1  out  1  one-cycle pulse: request latched
- ack0 / ack1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DATA_W  load result, valid from ack, held until next load ack on that port
- mem_load  out  1  memory LOAD strobe
- mem_store  out  1  memory STORE strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a mem_load cycle
- busy  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions IDLE→ACCESS (any req), ACCESS→RESP (always), RESP→IDLE (always).
- req/we/addr/wdata are sampled only at a clock edge while in IDLE. In other states they are ignored.
- Arbitration in IDLE:
  - A single requester wins.
  - If both request, the port not granted most recently wins.
  - Pointer `last` updates on every grant.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- On the IDLE→ACCESS edge, the winner's port id, we, addr and wdata are latched into internal registers.
- ACCESS:
  - gnt of the winner is high.
  - mem_addr is the latched addr.
  - mem_store = latched we; mem_load = !latched we.
  - mem_wdata = latched wdata.
- RESP:
  - mem_load and mem_store are low.
  - On the RESP→IDLE edge, for a load, mem_rdata is captured into the winner's rdata register.
  - ack of the winner is registered high for the following cycle (the first IDLE cycle).
- The ack cycle is also a normal IDLE cycle, so a new request can be sampled at its end.
- mem_load and mem_store are never both high. Both are low outside ACCESS.
- rdata of the non-winning port never changes. A store never changes either rdata register.
- mem_addr and mem_wdata hold their last values outside ACCESS.

## Timing
- Reset (async, immediate on rst_n low):
  - state = IDLE, last = 1.
  - gnt0/1, ack0/1, mem_load, mem_store and busy are all 0.
  - rdata0/1, mem_addr and mem_wdata are all 0.
- Reset mid-access: the in-flight access is dropped, with no ack and no rdata update. A store strobe in progress is deasserted immediately.
- Let E0 be the edge at which a request is sampled in IDLE. Then:
  - Cycle after E0: gnt and mem strobe high (ACCESS).
  - Next cycle: RESP.
  - Next cycle: ack high, and rdata is valid for a load.
- Request-to-ack latency is 3 cycles. Maximum throughput is one access per 3 cycles.
- A requester must drop req (or present a new request) in the cycle after gnt. A req still high in the ack cycle is treated as a new request.
- Back-to-back ties alternate: 0, 1, 0, 1, …
- A port requesting continuously alone is granted every 3 cycles. A losing port waits at most one access (3 cycles) before its grant.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 during ACCESS of a store to addr 5 with wdata 0xBEEF.
  - Required: mem_store drops immediately; no ack; after release, busy=0 and all outputs are 0.
- Single store/load on port 0:
  - Stimulus: store 0x1234 to addr 3, then load addr 3 (memory model returns 0x1234).
  - Required: gnt0 one cycle after sampling; ack0 3 cycles after E0; rdata0=0x1234 on the load ack; rdata1 stays 0.
- Tie:
  - Stimulus: req0 and req1 rise together and stay asserted (re-requesting after each gnt).
  - Required: grant order 0, 1, 0, 1; gnt pulses spaced 3 cycles apart; each port's ack follows its own gnt.
- Port isolation:
  - Stimulus: port 1 loads addr 7 (0xA5A5) while port 0 holds rdata0=0x1234.
  - Required: rdata1=0xA5A5 at ack1; rdata0 unchanged.
- Strobe exclusivity:
  - Stimulus: random req/we/addr on both ports for 2000 cycles.
  - Required:
    - mem_load & mem_store never both high.
    - Strobes only occur in ACCESS.
    - Every gnt is followed by exactly one ack on the same port 2 cycles later.
    - Scoreboard memory model matches every rdata.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 16-bit data memory.
// Every access runs IDLE -> ACCESS -> RESP; the per-port ack pulses in the following IDLE cycle.
module dmem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_load,
    output logic              mem_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic              last_reg;
    logic              port_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        ack_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic [1:0]        gnt_vec;
    logic              take;
    logic              win;

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    // On a tie the port not granted most recently wins; a lone requester always wins.
    always_comb begin
        take = (state_reg == IDLE) && (req_vec != 2'b00);
        win  = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                last_reg  <= win;
                port_reg  <= win;
                we_reg    <= we_vec[win];
                addr_reg  <= addr_vec[win];
                wdata_reg <= wdata_vec[win];
            end
        end
    end

    // Read data arrives during RESP and is captured on the way back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg <= 2'b00;
            for (int i = 0; i < 2; i++) rdata_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ack_reg[i] <= (state_reg == RESP) && (port_reg == 1'(i));
                if ((state_reg == RESP) && (port_reg == 1'(i)) && !we_reg)
                    rdata_reg[i] <= mem_rdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi] = (state_reg == ACCESS) && (port_reg == 1'(gi));
        end
    endgenerate

    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign ack0      = ack_reg[0];
    assign ack1      = ack_reg[1];
    assign rdata0    = rdata_reg[0];
    assign rdata1    = rdata_reg[1];
    assign mem_load  = (state_reg == ACCESS) && !we_reg;
    assign mem_store = (state_reg == ACCESS) && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed reset/store/load/tie cases, then random traffic
// against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_load, mem_store;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_load(mem_load), .mem_store(mem_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Physical memory attached to the DUT; preloaded from ref_mem once during reset.
    logic [DW-1:0] env_mem [8];
    logic [DW-1:0] ref_mem [8];
    logic          init_mem = 1'b0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) env_mem[i] <= ref_mem[i];
        end else if (mem_store) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        if (mem_load) mem_rdata <= env_mem[mem_addr];
    end

    // Transaction-level model: one outstanding access, timed by cycle numbers.
    int            cyc, g_cyc, free_cyc;
    logic          last_m, t_port, t_we;
    logic [AW-1:0] t_addr, exp_addr;
    logic [DW-1:0] t_wdata, t_rd, exp_wdata;
    logic [DW-1:0] exp_rd [2];
    int            n_checks = 0;
    int            n_errors = 0;
    int            gnt_port_q[$];
    int            gnt_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc       = 0;
        g_cyc     = -100;
        free_cyc  = 0;
        last_m    = 1'b1;
        t_port    = 1'b0;
        t_we      = 1'b0;
        t_addr    = '0;
        t_wdata   = '0;
        t_rd      = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic model_edge();
        logic w;
        if (cyc == g_cyc) begin
            if (t_we) ref_mem[t_addr] = t_wdata;
            else      t_rd = ref_mem[t_addr];
        end
        if (cyc >= free_cyc && (req0 || req1)) begin
            w         = (req0 && req1) ? ~last_m : req1;
            last_m    = w;
            t_port    = w;
            t_we      = w ? we1 : we0;
            t_addr    = w ? addr1 : addr0;
            t_wdata   = w ? wdata1 : wdata0;
            g_cyc     = cyc + 1;
            free_cyc  = cyc + 3;
            exp_addr  = t_addr;
            exp_wdata = t_wdata;
            $display("txn cycle=%0d port=%0d %s addr=%0d wdata=%h", g_cyc, t_port,
                     t_we ? "store" : "load", t_addr, t_wdata);
        end
        cyc = cyc + 1;
        if (cyc == g_cyc + 2 && !t_we) exp_rd[t_port] = t_rd;
    endtask

    task automatic check_outputs();
        logic acc;
        acc = (cyc == g_cyc);
        check("gnt0", 32'(gnt0), 32'(acc && t_port == 1'b0));
        check("gnt1", 32'(gnt1), 32'(acc && t_port == 1'b1));
        check("ack0", 32'(ack0), 32'(cyc == g_cyc + 2 && t_port == 1'b0));
        check("ack1", 32'(ack1), 32'(cyc == g_cyc + 2 && t_port == 1'b1));
        check("mem_load", 32'(mem_load), 32'(acc && !t_we));
        check("mem_store", 32'(mem_store), 32'(acc && t_we));
        check("strobe_excl", 32'(mem_load & mem_store), 32'd0);
        check("busy", 32'(busy), 32'(acc || cyc == g_cyc + 1));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        check("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        check("rdata1", 32'(rdata1), 32'(exp_rd[1]));
        if (gnt0 === 1'b1) begin gnt_port_q.push_back(0); gnt_cyc_q.push_back(cyc); end
        if (gnt1 === 1'b1) begin gnt_port_q.push_back(1); gnt_cyc_q.push_back(cyc); end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Present one request, drop it after the grant, and return in the ack cycle.
    task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'($urandom);
        ref_mem[7] = 16'hA5A5;
        model_reset();
        init_mem = 1'b1;
        repeat (2) @(negedge clk);
        init_mem = 1'b0;
        check_outputs();
        rst_n = 1'b1;

        // Reset in the middle of a store
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 16'hBEEF;
        step();
        check("rst_store_before", 32'(mem_store), 32'd1);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_store_drop", 32'(mem_store), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rst_no_write", 32'(env_mem[5]), 32'(ref_mem[5]));

        // Single store then load on port 0
        do_access(1'b0, 1'b1, 3'd3, 16'h1234);
        check("p0_store_ack", 32'(ack0), 32'd1);
        do_access(1'b0, 1'b0, 3'd3, 16'h0000);
        check("p0_load_ack", 32'(ack0), 32'd1);
        check("p0_load_rdata0", 32'(rdata0), 32'h1234);
        check("p0_load_rdata1", 32'(rdata1), 32'h0000);

        // Port isolation: port 1 load while rdata0 holds its value
        do_access(1'b1, 1'b0, 3'd7, 16'h0000);
        check("p1_load_ack", 32'(ack1), 32'd1);
        check("p1_load_rdata1", 32'(rdata1), 32'hA5A5);
        check("p1_keep_rdata0", 32'(rdata0), 32'h1234);

        // Tie with both ports requesting continuously
        gnt_port_q.delete();
        gnt_cyc_q.delete();
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h5A5A;
        repeat (12) step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();
        check("tie_count", 32'(gnt_port_q.size()), 32'd4);
        if (gnt_port_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("tie_order", 32'(gnt_port_q[i]), 32'(i % 2));
                if (i > 0) check("tie_spacing", 32'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 32'd3);
            end
        end

        // Random traffic on both ports
        repeat (2000) begin
            req0 = ($urandom_range(0, 1) == 1);
            req1 = ($urandom_range(0, 1) == 1);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 3'($urandom); addr1 = 3'($urandom);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
